pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed-field stage registers between ID/EX, EX/MEM and MEM/WB.
- Carries one control bundle, one data bundle and a PC per beat, with a valid/ready handshake, a flush and an optional two-entry skid buffer. Stalls never drop or duplicate an instruction.
- Instantiated once per pipeline boundary. The hazard unit drives flush; the downstream stage drives out_ready.

Parameters:
- CTRL_W, 16, width of control bundle (ALUSrc, ALUFun, MemRd, MemWr, RegWr, ...); flushed to 0.
- DATA_W, 128, width of data bundle (operands, immediate, instruction word); flushed to 0.
- RESET_PC, 32'h8000_0000, out_pc value after reset.
- FLUSH_PC, 32'h0000_0000, out_pc value after flush.
- SKID, 1, 1 = two-entry skid buffer (registered in_ready); 0 = single entry (combinational in_ready).
- CNT_W, 16, width of stall counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous; kill all held and incoming beats
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat
- in_ctrl  in  CTRL_W  control bundle
- in_data  in  DATA_W  data bundle
- in_pc  in  32  PC of beat
- out_valid  out  1  beat presented downstream
- out_ready  in  1  downstream accepts
- out_ctrl  out  CTRL_W  registered control
- out_data  out  DATA_W  registered data
- out_pc  out  32  registered PC
- stall_cnt  out  CNT_W  saturating count of back-pressured cycles

Behaviour:
- Reset (reset=0, asynchronous):
  - out_valid=0, out_ctrl=0, out_data=0, out_pc=RESET_PC.
  - Skid entry invalid and cleared; stall_cnt=0.
  - in_ready=1 from reset deassertion onward.
- Handshakes:
  - Accept when in_valid && in_ready.
  - Deliver when out_valid && out_ready.
  - in_valid/in_data are don't-care when in_ready=0.
  - out_* hold stable while out_valid && !out_ready.
- Latency: 1 cycle from accept to out_valid in the EMPTY state.
- SKID=1 states (occupancy):
  - EMPTY: main and skid entries invalid; in_ready=1.
  - ONE: main valid, skid invalid; in_ready=1.
  - FULL: both valid; in_ready=0 (registered, no combinational path from out_ready).
- SKID=1 transitions:
  - EMPTY, accept -> ONE (load main).
  - ONE, accept && deliver -> ONE (main reloads).
  - ONE, accept && !deliver -> FULL (load skid).
  - ONE, deliver && !accept -> EMPTY.
  - FULL, deliver -> ONE (skid moves to main, skid cleared).
  - FULL, !deliver -> FULL.
- SKID=0: single entry, in_ready = !out_valid || out_ready (combinational); FULL state does not exist.
- Bubble rule: when main drains with no replacement, out_ctrl is cleared to 0 (NOP control). out_data and out_pc retain their last values.
- Flush (synchronous, highest priority after reset):
  - Next state EMPTY; skid cleared.
  - out_ctrl=0, out_data=0, out_pc=FLUSH_PC.
  - A beat offered in the same cycle is dropped, even though in_ready may read 1.
- Flush during FULL: both entries are discarded.
- stall_cnt:
  - Increments each cycle with out_valid && !out_ready.
  - Saturates at 2^CNT_W-1; flush does not clear it; only reset does.
- Mid-operation reset: state returns to EMPTY immediately, regardless of pending beats.
- Ordering: beats always leave in acceptance order. The skid entry is never presented before main.

Decomposition:
- Shared package pipe_pkg: occupancy encoding (OCC_EMPTY=2'b00, OCC_ONE=2'b01, OCC_FULL=2'b10), RESET_PC/FLUSH_PC default constants, and per-boundary CTRL_W/DATA_W constants (ID2EX, EX2MEM, MEM2WB).
- One natural sub-module: pipe_entry, a single {valid, ctrl, data, pc} register with load/clear/flush-value inputs. It is instantiated as main and as skid.
- Occupancy logic and stall counter stay in the top level.

Test Plan:
- Reset: hold reset=0 mid-stream -> out_valid=0, out_pc=32'h8000_0000, out_ctrl=0, stall_cnt=0, in_ready=1 after release.
- Streaming: out_ready=1, beats pc=0x0,0x4,0x8 on consecutive cycles -> each appears exactly 1 cycle later, in order, with no gaps.
- Back-pressure (SKID=1): out_ready=0 for 3 cycles while offering 0x10,0x14,0x18 -> 0x10 and 0x14 are held and in_ready=0. Then out_ready=1 -> 0x10, 0x14, 0x18 are delivered in order with none lost. stall_cnt=3.
- Flush in FULL with simultaneous in_valid pc=0x20 -> next cycle out_valid=0, out_ctrl=0, out_pc=0, and 0x20 is never delivered.
- Drain bubble: a single beat with ctrl=16'hFFFF is delivered with no follow-up -> next cycle out_valid=0, out_ctrl=0, out_pc unchanged.
- SKID=0 with CNT_W=2: out_ready=0 for 5 cycles -> in_ready tracks out_ready combinationally, and stall_cnt saturates at 3.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: occupancy encoding,
// default PC values and per-boundary bundle widths.
package pipe_pkg;

    localparam int PC_W = 32;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'b00,
        OCC_ONE   = 2'b01,
        OCC_FULL  = 2'b10
    } occ_e;

    localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [PC_W-1:0] FLUSH_PC_DEF = 32'h0000_0000;

    localparam int ID2EX_CTRL_W  = 16;
    localparam int ID2EX_DATA_W  = 128;
    localparam int EX2MEM_CTRL_W = 8;
    localparam int EX2MEM_DATA_W = 96;
    localparam int MEM2WB_CTRL_W = 4;
    localparam int MEM2WB_DATA_W = 64;

endpackage

// File: rtl/pipe_entry.sv
// One {valid, ctrl, data, pc} holding register. Flush wipes everything,
// load captures a beat, drain leaves a bubble (NOP ctrl, data/pc kept).
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int              CTRL_W   = 16,
    parameter int              DATA_W   = 128,
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [PC_W-1:0] FLUSH_PC = FLUSH_PC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              load,
    input  logic              drain,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    input  logic [PC_W-1:0]   d_pc,
    output logic              q_valid,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data,
    output logic [PC_W-1:0]   q_pc
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [PC_W-1:0]   pc_q, pc_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            data_d  = '0;
            pc_d    = FLUSH_PC;
        end else if (load) begin
            valid_d = 1'b1;
            ctrl_d  = d_ctrl;
            data_d  = d_data;
            pc_d    = d_pc;
        end else if (drain) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end
    end

    // NOTE: state flops use non-blocking assignments; the data register is reset too
    // because out_data is architecturally visible right after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
            pc_q    <= RESET_PC;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
        end
    end

    assign q_valid = valid_q;
    assign q_ctrl  = ctrl_q;
    assign q_data  = data_q;
    assign q_pc    = pc_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline boundary register with flush, optional two-entry
// skid buffer and a saturating back-pressure counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int              CTRL_W   = ID2EX_CTRL_W,
    parameter int              DATA_W   = ID2EX_DATA_W,
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [PC_W-1:0] FLUSH_PC = FLUSH_PC_DEF,
    parameter int              SKID     = 1,
    parameter int              CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [31:0]       in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [31:0]       out_pc,
    output logic [CNT_W-1:0]  stall_cnt
);

    occ_e             occ_q, occ_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic accept, deliver;
    logic main_load, main_drain, skid_load, skid_clear;

    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl,  main_d_ctrl;
    logic [DATA_W-1:0] skid_data,  main_d_data;
    logic [PC_W-1:0]   skid_pc,    main_d_pc;

    // With a skid entry in_ready comes straight from a flop, cutting the
    // out_ready -> in_ready path; without one it must look at out_ready.
    generate
        if (SKID != 0) begin : g_skid_ready
            assign in_ready = (occ_q != OCC_FULL);
        end else begin : g_single_ready
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

    assign accept  = in_valid && in_ready;
    assign deliver = out_valid && out_ready;

    always_comb begin
        occ_d      = occ_q;
        main_load  = 1'b0;
        main_drain = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (!flush) begin
            unique case (occ_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        main_load = 1'b1;
                        occ_d     = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (accept && deliver) begin
                        main_load = 1'b1;
                    end else if (accept && (SKID != 0)) begin
                        skid_load = 1'b1;
                        occ_d     = OCC_FULL;
                    end else if (deliver) begin
                        main_drain = 1'b1;
                        occ_d      = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (deliver) begin
                        main_load  = 1'b1;
                        skid_clear = 1'b1;
                        occ_d      = OCC_ONE;
                    end
                end
                default: occ_d = OCC_EMPTY;
            endcase
        end else begin
            occ_d = OCC_EMPTY;
        end
    end

    // Main refills from the skid entry whenever one is waiting, keeping order.
    assign main_d_ctrl = skid_valid ? skid_ctrl : in_ctrl;
    assign main_d_data = skid_valid ? skid_data : in_data;
    assign main_d_pc   = skid_valid ? skid_pc   : in_pc;

    pipe_entry #(
        .CTRL_W  (CTRL_W),
        .DATA_W  (DATA_W),
        .RESET_PC(RESET_PC),
        .FLUSH_PC(FLUSH_PC)
    ) u_main (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .load   (main_load),
        .drain  (main_drain),
        .d_ctrl (main_d_ctrl),
        .d_data (main_d_data),
        .d_pc   (main_d_pc),
        .q_valid(out_valid),
        .q_ctrl (out_ctrl),
        .q_data (out_data),
        .q_pc   (out_pc)
    );

    pipe_entry #(
        .CTRL_W  (CTRL_W),
        .DATA_W  (DATA_W),
        .RESET_PC('0),
        .FLUSH_PC('0)
    ) u_skid (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush || skid_clear),
        .load   (skid_load),
        .drain  (1'b0),
        .d_ctrl (in_ctrl),
        .d_data (in_data),
        .d_pc   (in_pc),
        .q_valid(skid_valid),
        .q_ctrl (skid_ctrl),
        .q_data (skid_data),
        .q_pc   (skid_pc)
    );

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_q       <= OCC_EMPTY;
            stall_cnt_q <= '0;
        end else begin
            occ_q       <= occ_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: a SKID=1 instance and a SKID=0/CNT_W=2 instance share stimulus.
module tb_pipe_stage_reg;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic [15:0]  in_ctrl;
    logic [127:0] in_data;
    logic [31:0]  in_pc;
    logic         out_ready;

    logic         in_ready1, out_valid1;
    logic [15:0]  out_ctrl1;
    logic [127:0] out_data1;
    logic [31:0]  out_pc1;
    logic [15:0]  stall1;

    logic         in_ready0, out_valid0;
    logic [15:0]  out_ctrl0;
    logic [127:0] out_data0;
    logic [31:0]  out_pc0;
    logic [1:0]   stall0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.SKID(1), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_pc(in_pc),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_ctrl(out_ctrl1), .out_data(out_data1), .out_pc(out_pc1),
        .stall_cnt(stall1)
    );

    pipe_stage_reg #(.SKID(0), .CNT_W(2)) dut0 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_pc(in_pc),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_ctrl(out_ctrl0), .out_data(out_data0), .out_pc(out_pc0),
        .stall_cnt(stall0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [15:0] ctrl);
        in_valid = v;
        in_pc    = pc;
        in_ctrl  = ctrl;
        in_data  = {4{pc}};
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b1, 32'h1234, 16'hABCD);
        tick();
        n_checks++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", out_valid1); end
        n_checks++; if (out_pc1 !== 32'h8000_0000) begin n_fail++; $display("FAIL rst_pc got %h exp 80000000", out_pc1); end
        n_checks++; if (out_ctrl1 !== 16'h0) begin n_fail++; $display("FAIL rst_ctrl got %h exp 0", out_ctrl1); end
        n_checks++; if (out_data1 !== 128'h0) begin n_fail++; $display("FAIL rst_data got %h exp 0", out_data1); end
        n_checks++; if (stall1 !== 16'd0) begin n_fail++; $display("FAIL rst_stall got %0d exp 0", stall1); end
        drive(1'b0, 32'h0, 16'h0);
        reset = 1'b1;
        tick();
        n_checks++; if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b exp 1", in_ready1); end
        n_checks++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL rst_idle_valid got %b exp 0", out_valid1); end
    endtask

    task automatic test_streaming();
        logic [31:0] pcs [3];
        logic [15:0] ctrls [3];
        pcs   = '{32'h0, 32'h4, 32'h8};
        ctrls = '{16'h0011, 16'h0022, 16'h0033};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, pcs[i], ctrls[i]);
            tick();
            n_checks++; if (out_valid1 !== 1'b1 || out_pc1 !== pcs[i] || out_ctrl1 !== ctrls[i]) begin
                n_fail++; $display("FAIL stream_%0d got v=%b pc=%h ctrl=%h exp v=1 pc=%h ctrl=%h",
                                   i, out_valid1, out_pc1, out_ctrl1, pcs[i], ctrls[i]);
            end
        end
        drive(1'b0, 32'h0, 16'h0);
        tick();
        n_checks++; if (out_valid1 !== 1'b0 || out_ctrl1 !== 16'h0 || out_pc1 !== 32'h8) begin
            n_fail++; $display("FAIL stream_end got v=%b ctrl=%h pc=%h exp v=0 ctrl=0 pc=8", out_valid1, out_ctrl1, out_pc1);
        end
        n_checks++; if (stall1 !== 16'd0) begin n_fail++; $display("FAIL stream_stall got %0d exp 0", stall1); end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        drive(1'b1, 32'h10, 16'h0101);
        tick();
        n_checks++; if (out_valid1 !== 1'b1 || out_pc1 !== 32'h10 || in_ready1 !== 1'b1) begin
            n_fail++; $display("FAIL bp_one got v=%b pc=%h rdy=%b exp v=1 pc=10 rdy=1", out_valid1, out_pc1, in_ready1);
        end
        drive(1'b1, 32'h14, 16'h0102);
        tick();
        n_checks++; if (in_ready1 !== 1'b0 || out_pc1 !== 32'h10) begin
            n_fail++; $display("FAIL bp_full got rdy=%b pc=%h exp rdy=0 pc=10", in_ready1, out_pc1);
        end
        drive(1'b1, 32'h18, 16'h0103);
        tick();
        tick();
        n_checks++; if (stall1 !== 16'd3) begin n_fail++; $display("FAIL bp_stall got %0d exp 3", stall1); end
        n_checks++; if (in_ready1 !== 1'b0 || out_pc1 !== 32'h10 || out_ctrl1 !== 16'h0101) begin
            n_fail++; $display("FAIL bp_hold got rdy=%b pc=%h ctrl=%h exp rdy=0 pc=10 ctrl=0101", in_ready1, out_pc1, out_ctrl1);
        end
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_valid1 !== 1'b1 || out_pc1 !== 32'h14 || out_ctrl1 !== 16'h0102 || in_ready1 !== 1'b1) begin
            n_fail++; $display("FAIL bp_drain1 got v=%b pc=%h ctrl=%h rdy=%b exp v=1 pc=14 ctrl=0102 rdy=1",
                               out_valid1, out_pc1, out_ctrl1, in_ready1);
        end
        tick();
        n_checks++; if (out_valid1 !== 1'b1 || out_pc1 !== 32'h18 || out_data1 !== {4{32'h18}}) begin
            n_fail++; $display("FAIL bp_drain2 got v=%b pc=%h exp v=1 pc=18", out_valid1, out_pc1);
        end
        drive(1'b0, 32'h0, 16'h0);
        tick();
        n_checks++; if (out_valid1 !== 1'b0 || stall1 !== 16'd3) begin
            n_fail++; $display("FAIL bp_empty got v=%b stall=%0d exp v=0 stall=3", out_valid1, stall1);
        end
    endtask

    task automatic test_flush_full();
        out_ready = 1'b0;
        drive(1'b1, 32'h30, 16'h0301);
        tick();
        drive(1'b1, 32'h34, 16'h0302);
        tick();
        n_checks++; if (in_ready1 !== 1'b0) begin n_fail++; $display("FAIL fl_full got rdy=%b exp 0", in_ready1); end
        flush = 1'b1;
        drive(1'b1, 32'h20, 16'h0F0F);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 16'h0);
        n_checks++; if (out_valid1 !== 1'b0 || out_ctrl1 !== 16'h0 || out_pc1 !== 32'h0 || out_data1 !== 128'h0) begin
            n_fail++; $display("FAIL fl_state got v=%b ctrl=%h pc=%h data=%h exp all 0", out_valid1, out_ctrl1, out_pc1, out_data1);
        end
        n_checks++; if (stall1 !== 16'd5) begin n_fail++; $display("FAIL fl_stall got %0d exp 5", stall1); end
        n_checks++; if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL fl_ready got %b exp 1", in_ready1); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (out_valid1 !== 1'b0) begin
                n_fail++; $display("FAIL fl_leak_%0d got v=%b pc=%h exp v=0", i, out_valid1, out_pc1);
            end
        end
    endtask

    task automatic test_drain_bubble();
        out_ready = 1'b1;
        drive(1'b1, 32'h40, 16'hFFFF);
        tick();
        drive(1'b0, 32'h0, 16'h0);
        n_checks++; if (out_valid1 !== 1'b1 || out_ctrl1 !== 16'hFFFF || out_pc1 !== 32'h40) begin
            n_fail++; $display("FAIL bub_beat got v=%b ctrl=%h pc=%h exp v=1 ctrl=ffff pc=40", out_valid1, out_ctrl1, out_pc1);
        end
        tick();
        n_checks++; if (out_valid1 !== 1'b0 || out_ctrl1 !== 16'h0 || out_pc1 !== 32'h40 || out_data1 !== {4{32'h40}}) begin
            n_fail++; $display("FAIL bub_after got v=%b ctrl=%h pc=%h exp v=0 ctrl=0 pc=40 data kept", out_valid1, out_ctrl1, out_pc1);
        end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        drive(1'b1, 32'h50, 16'h0501);
        tick();
        drive(1'b1, 32'h54, 16'h0502);
        tick();
        reset = 1'b0;
        #1;
        n_checks++; if (out_valid1 !== 1'b0 || out_pc1 !== 32'h8000_0000 || out_ctrl1 !== 16'h0 || stall1 !== 16'd0) begin
            n_fail++; $display("FAIL mrst got v=%b pc=%h ctrl=%h stall=%0d exp v=0 pc=80000000 ctrl=0 stall=0",
                               out_valid1, out_pc1, out_ctrl1, stall1);
        end
        n_checks++; if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL mrst_ready got %b exp 1", in_ready1); end
        drive(1'b0, 32'h0, 16'h0);
        out_ready = 1'b1;
        reset = 1'b1;
        tick();
        n_checks++; if (out_valid1 !== 1'b0 || out_valid0 !== 1'b0) begin
            n_fail++; $display("FAIL mrst_stale got v1=%b v0=%b exp 0", out_valid1, out_valid0);
        end
    endtask

    task automatic test_skid0();
        out_ready = 1'b0;
        drive(1'b1, 32'h60, 16'h0601);
        #1;
        n_checks++; if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL s0_empty_ready got %b exp 1", in_ready0); end
        tick();
        drive(1'b1, 32'h64, 16'h0602);
        n_checks++; if (out_valid0 !== 1'b1 || out_pc0 !== 32'h60 || in_ready0 !== 1'b0) begin
            n_fail++; $display("FAIL s0_load got v=%b pc=%h rdy=%b exp v=1 pc=60 rdy=0", out_valid0, out_pc0, in_ready0);
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL s0_comb_hi got %b exp 1", in_ready0); end
        out_ready = 1'b0;
        #1;
        n_checks++; if (in_ready0 !== 1'b0) begin n_fail++; $display("FAIL s0_comb_lo got %b exp 0", in_ready0); end
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_checks++; if (stall0 !== ((k < 3) ? 2'(k) : 2'd3) || out_pc0 !== 32'h60) begin
                n_fail++; $display("FAIL s0_stall_%0d got cnt=%0d pc=%h exp cnt=%0d pc=60", k, stall0, out_pc0, (k < 3) ? k : 3);
            end
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL s0_release_ready got %b exp 1", in_ready0); end
        tick();
        drive(1'b0, 32'h0, 16'h0);
        n_checks++; if (out_valid0 !== 1'b1 || out_pc0 !== 32'h64 || out_ctrl0 !== 16'h0602) begin
            n_fail++; $display("FAIL s0_next got v=%b pc=%h ctrl=%h exp v=1 pc=64 ctrl=0602", out_valid0, out_pc0, out_ctrl0);
        end
        tick();
        n_checks++; if (out_valid0 !== 1'b0 || stall0 !== 2'd3) begin
            n_fail++; $display("FAIL s0_end got v=%b cnt=%0d exp v=0 cnt=3", out_valid0, stall0);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush_full();
        test_drain_bubble();
        test_mid_reset();
        test_skid0();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
